// File: rtl/multichan_signal_gen.sv
// rtl/multichan_signal_gen.sv - multi-channel phase-accumulator oscillators mixed into a 1-bit PWM output
// Optional feature macro: PHASE_RESET_EN (ctrl writes clear the channel phase and reseed its LFSR)
module multichan_signal_gen #(
  parameter int CHANNELS = 2,
  parameter int ACC_W    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           write_strobe,
  input  logic [$clog2(CHANNELS)+1:0]    address,
  input  logic [4:0]                     data,
  output logic                           signal_out,
  output logic [6:0]                     debug
);

  localparam int CH_BITS = $clog2(CHANNELS);
  localparam int ADDR_W  = CH_BITS + 2;
  localparam int SUM_W   = 8 + CH_BITS;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic              sync1, sync2, prev;
  logic              commit;
  logic [7:0]        pwm_cnt;
  logic              tick;
  logic [7:0]        mix_latched;
  logic [ADDR_W-1:0] ch_field;
  logic [1:0]        reg_sel;
  logic [7:0]        scaled [CHANNELS];
  logic [SUM_W-1:0]  mix_sum;
  logic [7:0]        mix_next;

  assign commit   = sync2 & ~prev;
  assign tick     = (pwm_cnt == 8'd255);
  assign reg_sel  = address[1:0];
  assign ch_field = address >> 2;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [14:0]      inc;
    logic [4:0]       ctrl;
    logic [ACC_W-1:0] acc;
    logic [15:0]      lfsr;
    logic [ACC_W-1:0] acc_next;
    logic [15:0]      lfsr_next;
    logic             rise;
    logic             hit;
    logic [6:0]       t;
    logic [7:0]       wave;

    assign hit       = commit && (ch_field == ADDR_W'(c));
    assign acc_next  = acc + ACC_W'(inc);
    assign rise      = ~acc[ACC_W-1] & acc_next[ACC_W-1];
    assign lfsr_next = rise ? {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]} : lfsr;
    assign t         = acc_next[ACC_W-2 -: 7];

    // Wave is taken from the post-tick phase so mix_latched tracks the new accumulator.
    always_comb begin
      wave = 8'd0;
      unique case (ctrl[1:0])
        2'd0: wave = {8{acc_next[ACC_W-1]}};
        2'd1: wave = acc_next[ACC_W-1 -: 8];
        2'd2: wave = {(acc_next[ACC_W-1] ? ~t : t), 1'b0};
        2'd3: wave = lfsr_next[7:0];
      endcase
    end

    assign scaled[c] = (ctrl[4:2] == 3'd0) ? 8'd0 : (wave >> (3'd7 - ctrl[4:2]));

    always_ff @(posedge clk) begin
      if (rst) begin
        inc  <= '0;
        ctrl <= '0;
        acc  <= '0;
        lfsr <= LFSR_SEED;
      end else begin
        if (tick) begin
          acc  <= acc_next;
          lfsr <= lfsr_next;
        end
        if (hit) begin
          unique case (reg_sel)
            2'd0: inc[4:0]   <= data;
            2'd1: inc[9:5]   <= data;
            2'd2: inc[14:10] <= data;
            2'd3: ctrl       <= data;
          endcase
        end
`ifdef PHASE_RESET_EN
        // Retrigger: placed after the tick update so the clear wins on a coincident edge.
        if (hit && reg_sel == 2'd3) begin
          acc  <= '0;
          lfsr <= LFSR_SEED;
        end
`endif
      end
    end
  end

  always_comb begin
    mix_sum = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      mix_sum = mix_sum + SUM_W'(scaled[c]);
    end
    mix_next = 8'(mix_sum >> CH_BITS);
  end

  // Sync flops reset high so a strobe held through reset cannot look like a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      prev        <= 1'b1;
      pwm_cnt     <= 8'd0;
      mix_latched <= 8'd0;
      signal_out  <= 1'b0;
    end else begin
      sync1      <= write_strobe;
      sync2      <= sync1;
      prev       <= sync2;
      pwm_cnt    <= pwm_cnt + 8'd1;
      if (tick) begin
        mix_latched <= mix_next;
      end
      signal_out <= (pwm_cnt < mix_latched);
    end
  end

  assign debug = mix_latched[7:1];

endmodule

// File: doc/multichan_signal_gen.md
Name: multichan_signal_gen

Overview:
Parametrised multi-channel successor to the single-channel signal generator. Has CHANNELS independent phase-accumulator oscillators, each with a selectable waveform (square, saw, triangle, LFSR noise) and a 3-bit volume. Oscillator outputs are averaged into one 8-bit sample that drives a 1-bit PWM output pin. Sits directly under the chip top level; it is programmed via the existing strobe/address/5-bit-data pin interface.

Parameters:
CHANNELS, 2, number of oscillators; power of two, 1..4
ACC_W, 16, phase accumulator width; must be >= 15

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
write_strobe  in  1  asynchronous write strobe; a write occurs on its rising edge
address  in  2+log2(CHANNELS)  {channel, reg[1:0]}
data  in  5  write data
signal_out  out  1  PWM audio output
debug  out  7  mix_latched[7:1]

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Strobe: 2-FF synchroniser plus a prev flop. The write commits on the clk edge where sync2=1 and prev=0, which is the 3rd rising edge after strobe rises. address/data are sampled on that same edge and must be stable for 3 cycles.
- Reset values: sync1, sync2 and prev reset to 1, so a strobe held high through reset produces no write. Registers, accumulators and pwm_cnt reset to 0. mix_latched resets to 0. Each LFSR resets to 16'hACE1. signal_out=0, debug=0.
- Per-channel registers:
  - reg0 = inc[4:0]; reg1 = inc[9:5]; reg2 = inc[14:10].
  - reg3 = ctrl: [1:0] wave (0 square, 1 saw, 2 triangle, 3 noise), [4:2] vol.
- PWM: 8-bit pwm_cnt increments every cycle and wraps 255->0. A tick is the cycle where pwm_cnt==255, so the sample rate is clk/256.
- On a tick, each channel does acc <= acc + inc, modulo 2^ACC_W (wraps silently; inc=0 holds phase). The update uses register values as of before that edge. A write on the tick cycle takes effect from the next tick.
- Wave value w (8 bit), taken from post-update acc:
  - Square: acc[MSB] ? 255 : 0.
  - Saw: acc[ACC_W-1 -: 8].
  - Triangle: t = acc[ACC_W-2 -: 7]; w = {(acc[MSB] ? ~t : t), 1'b0}.
  - Noise: lfsr[7:0]. The LFSR (x^16+x^14+x^13+x^11+1, Fibonacci, shift left) advances on each tick where acc[MSB] goes 0->1.
- Volume: scaled = (vol==0) ? 0 : w >> (7-vol).
- Mixer: sum of scaled over all channels, right-shifted by log2(CHANNELS) to 8 bits (no overflow by construction). On a tick, the mixer result is registered into mix_latched, with the same-edge accumulator update; i.e. mix_latched reflects the new acc values one cycle after the tick.
- signal_out = registered (pwm_cnt < mix_latched), giving duty mix/256. mix=0 gives a constant 0; 255 gives 255 of 256 cycles high.
- debug = mix_latched[7:1], combinational from the register.
- Reset mid-operation: all state returns to reset values on the next edge. Pending (synchronising) writes are dropped.

Optional Feature:
PHASE_RESET_EN: when defined, a committed write to a channel's reg3 also clears that channel's acc to 0 and reseeds its LFSR to 16'hACE1 on the same edge. This enables phase-aligned retriggering. If the write coincides with a tick, the clear wins. When not defined, ctrl writes leave phase and LFSR untouched.

Test Plan:
- Reset with strobe held high, release after 5 cycles -> no register changes; signal_out=0, debug=0 for 1024 cycles.
- Strobe pulse, addr=3, data=5'b11101 -> ch0 wave=1, vol=7 visible on the 3rd clk edge after the strobe rises; not visible on the 2nd.
- ch0 saw, vol 7, inc=256 (reg1=8), ch1 muted -> after tick k, mix_latched = (k mod 256)>>1; signal_out high for mix_latched of every 256 cycles.
- ch0 square, vol 7, inc=16384 (reg2=16), ch1 muted -> mix_latched sequence 0,127,127,0,0,127,... across ticks 1..6.
- Both channels square, vol 7, inc=32768 -> mix alternates 255 / 0; ch1 at vol 6 instead -> 255+127 >>1 = 191.
- PHASE_RESET_EN defined, ch0 saw running, rewrite reg3 -> acc=0 on the commit edge and next-tick mix restarts from inc; without the macro, the sawtooth continues uninterrupted.
